// File: rtl/lane_packer_pkg.sv
// Shared definitions for the lane packer.
//   emit_state_e : output beat state (idle / accumulating a partial beat / emitting)
//   safe_clog2   : width helper that never returns 0, so 1-deep or 1-lane cases still get a 1-bit field
//   popcount     : number of set bits in a lane-valid vector (up to 32 lanes)
package lane_packer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_EMIT  = 2'd2
    } emit_state_e;

    function automatic int safe_clog2(input int value);
        return (value < 2) ? 1 : $clog2(value);
    endfunction

    function automatic int popcount(input logic [31:0] bits);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + int'(bits[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/lane_packer_compact.sv
// Combinational lane compaction.
// Moves every valid input word down to the lowest free slot, preserving lane order
// (a running prefix count over s_valid gives each valid lane its slot), and reports
// how many words were valid. Slots at and above c_cnt are driven to zero.
//   s_valid : per-lane valid
//   s_data  : input words, lane 0 oldest
//   c_data  : compacted words, slot 0 oldest
//   c_cnt   : popcount of s_valid
module lane_packer_compact
    import lane_packer_pkg::*;
#(
    parameter int LANE_IN = 4,
    parameter int WIDTH   = 16,
    parameter int CNT_W   = safe_clog2(LANE_IN + 1)
) (
    input  logic [LANE_IN-1:0] s_valid,
    input  logic [WIDTH-1:0]   s_data [LANE_IN],
    output logic [WIDTH-1:0]   c_data [LANE_IN],
    output logic [CNT_W-1:0]   c_cnt
);

    localparam int IDX_W = safe_clog2(LANE_IN);

    always_comb begin
        logic [IDX_W-1:0] slot;
        slot = '0;
        for (int i = 0; i < LANE_IN; i++) begin
            c_data[i] = '0;
        end
        for (int i = 0; i < LANE_IN; i++) begin
            if (s_valid[i]) begin
                c_data[slot] = s_data[i];
                // Wraps only after the last lane has been placed, so it is never reused.
                slot = slot + 1'b1;
            end
        end
        c_cnt = CNT_W'(popcount(32'(s_valid)));
    end

endmodule

// File: rtl/lane_packer.sv
// Sparse-lane packer: compacts up to LANE_IN valid words per cycle, buffers them in
// lane order and emits up to LANE_OUT words per beat under valid/ready.
// Whole input beats are dropped (and counted) when the buffer lacks room; the first
// word accepted after a drop is tagged so the consumer sees m_overflow on its beat.
// A partial beat (fewer than LANE_OUT words) is emitted after FLUSH_TIMEOUT idle cycles.
//   clk, rst   : clock, asynchronous active-high reset
//   s_valid    : per-lane input valid (no backpressure)
//   s_data     : input words, lane 0 oldest
//   m_ready    : consumer accepts the current beat
//   m_valid    : beat present
//   m_data     : beat words, lane 0 oldest (unkept lanes read as zero)
//   m_keep     : kept lanes, contiguous from lane 0
//   m_overflow : beat carries the first word accepted after one or more drops
//   fill_level : words currently buffered
//   drop_count : dropped input beats, saturating
module lane_packer
    import lane_packer_pkg::*;
#(
    parameter int LANE_IN       = 4,
    parameter int LANE_OUT      = 2,
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 64,
    parameter int FLUSH_TIMEOUT = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [LANE_IN-1:0]      s_valid,
    input  logic [WIDTH-1:0]        s_data [LANE_IN],
    input  logic                    m_ready,
    output logic                    m_valid,
    output logic [WIDTH-1:0]        m_data [LANE_OUT],
    output logic [LANE_OUT-1:0]     m_keep,
    output logic                    m_overflow,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic [31:0]             drop_count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH) + 1;
    localparam int CNT_W  = safe_clog2(LANE_IN + 1);
    localparam int OUT_W  = safe_clog2(LANE_OUT + 1);
    localparam int TMR_W  = safe_clog2(FLUSH_TIMEOUT + 1);

    typedef struct packed {
        logic             ovf;
        logic [WIDTH-1:0] data;
    } entry_t;

    // Compaction (combinational), registered below as S1
    logic [WIDTH-1:0] c_data [LANE_IN];
    logic [CNT_W-1:0] c_cnt;

    lane_packer_compact #(
        .LANE_IN (LANE_IN),
        .WIDTH   (WIDTH),
        .CNT_W   (CNT_W)
    ) u_compact (
        .s_valid (s_valid),
        .s_data  (s_data),
        .c_data  (c_data),
        .c_cnt   (c_cnt)
    );

    logic [WIDTH-1:0]  s1_data_d [LANE_IN];
    logic [WIDTH-1:0]  s1_data_q [LANE_IN];
    logic [CNT_W-1:0]  s1_cnt_d,  s1_cnt_q;
    logic [PTR_W-1:0]  wr_ptr_d,  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d,  rd_ptr_q;
    logic [FILL_W-1:0] fill_d,    fill_q;
    logic [TMR_W-1:0]  timer_d,   timer_q;
    logic [31:0]       drop_count_d, drop_count_q;
    logic              pending_ovf_d, pending_ovf_q;
    logic              hold_d,    hold_q;
    logic [OUT_W-1:0]  n_hold_d,  n_hold_q;

    entry_t mem_q [DEPTH];

    logic [FILL_W-1:0] free_words;
    logic              wr_en;
    logic              drop;
    logic [CNT_W-1:0]  n_wr;
    logic [OUT_W-1:0]  live_n;
    logic [OUT_W-1:0]  n_out;
    logic [OUT_W-1:0]  n_pop;
    logic              threshold;
    logic              pop;
    emit_state_e       state;

    always_comb begin
        for (int i = 0; i < LANE_IN; i++) begin
            s1_data_d[i] = c_data[i];
        end
        s1_cnt_d = c_cnt;

        // Admission looks only at the registered level; a pop in this cycle is not credited.
        free_words = FILL_W'(DEPTH) - fill_q;
        wr_en      = (s1_cnt_q != '0) && (FILL_W'(s1_cnt_q) <= free_words);
        drop       = (s1_cnt_q != '0) && !wr_en;
        n_wr       = wr_en ? s1_cnt_q : '0;

        live_n    = (fill_q >= FILL_W'(LANE_OUT)) ? OUT_W'(LANE_OUT) : OUT_W'(fill_q);
        threshold = (fill_q != '0) &&
                    ((fill_q >= FILL_W'(LANE_OUT)) ||
                     (timer_q == TMR_W'(FLUSH_TIMEOUT)) ||
                     (FLUSH_TIMEOUT == 0));

        // A presented beat stays valid and keeps its size until popped, even if
        // later writes would otherwise enlarge a partial beat.
        m_valid = hold_q || threshold;
        n_out   = hold_q ? n_hold_q : live_n;
        pop     = m_valid && m_ready;
        n_pop   = pop ? n_out : '0;

        if (fill_q == '0) begin
            state = ST_IDLE;
        end else if (m_valid) begin
            state = ST_EMIT;
        end else begin
            state = ST_ACCUM;
        end

        fill_d   = fill_q + FILL_W'(n_wr) - FILL_W'(n_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(n_pop);

        if ((n_wr != '0) || pop || (state == ST_IDLE)) begin
            timer_d = '0;
        end else if (state == ST_ACCUM) begin
            timer_d = timer_q + 1'b1;
        end else begin
            timer_d = timer_q;
        end

        hold_d   = m_valid && !m_ready;
        n_hold_d = n_out;

        if (drop) begin
            pending_ovf_d = 1'b1;
        end else if (wr_en) begin
            pending_ovf_d = 1'b0;
        end else begin
            pending_ovf_d = pending_ovf_q;
        end

        if (drop && (drop_count_q != '1)) begin
            drop_count_d = drop_count_q + 32'd1;
        end else begin
            drop_count_d = drop_count_q;
        end
    end

    // Output beat, read straight from the buffer at rd_ptr
    always_comb begin
        logic [PTR_W-1:0] rd_idx;
        m_overflow = 1'b0;
        for (int i = 0; i < LANE_OUT; i++) begin
            rd_idx     = rd_ptr_q + PTR_W'(i);
            m_keep[i]  = m_valid && (OUT_W'(i) < n_out);
            m_data[i]  = m_keep[i] ? mem_q[rd_idx].data : '0;
            m_overflow = m_overflow | (m_keep[i] & mem_q[rd_idx].ovf);
        end
    end

    assign fill_level = fill_q;
    assign drop_count = drop_count_q;

    // Control state: S1 word count, S2 pointers/level, timer, drop bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_cnt_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fill_q        <= '0;
            timer_q       <= '0;
            drop_count_q  <= '0;
            pending_ovf_q <= 1'b0;
            hold_q        <= 1'b0;
            n_hold_q      <= '0;
        end else begin
            s1_cnt_q      <= s1_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            fill_q        <= fill_d;
            timer_q       <= timer_d;
            drop_count_q  <= drop_count_d;
            pending_ovf_q <= pending_ovf_d;
            hold_q        <= hold_d;
            n_hold_q      <= n_hold_d;
        end
    end

    // Data path: S1 compacted words, S2 buffer write (no reset on data)
    always_ff @(posedge clk) begin
        s1_data_q <= s1_data_d;
        for (int k = 0; k < LANE_IN; k++) begin
            if (wr_en && (CNT_W'(k) < s1_cnt_q)) begin
                // Only word 0 of the first beat accepted after a drop carries the flag.
                mem_q[wr_ptr_q + PTR_W'(k)] <= '{ovf: pending_ovf_q && (k == 0),
                                                 data: s1_data_q[k]};
            end
        end
    end

endmodule

// File: tb/tb_lane_packer.sv
// Directed bench for lane_packer with a word scoreboard.
// Every driven word gets a unique value and is queued with its expected overflow tag;
// a monitor pops the queue on each accepted beat. Beats marked droppable (continuous
// streaming) may be skipped as whole beats; a skip makes the next word carry overflow.
module tb_lane_packer;

    typedef struct {
        logic [15:0] data;
        bit          ovf;
        bit          droppable;
    } sb_entry_t;

    logic        clk;
    logic        rst;
    logic [3:0]  s_valid;
    logic [15:0] s_data [4];
    logic        m_ready;
    logic        m_valid;
    logic [15:0] m_data [2];
    logic [1:0]  m_keep;
    logic        m_overflow;
    logic [6:0]  fill_level;
    logic [31:0] drop_count;

    int          checks;
    int          failures;
    int          total_skipped;
    bit          lazy_pending;
    logic [15:0] seq;
    sb_entry_t   sb[$];

    lane_packer #(
        .LANE_IN       (4),
        .LANE_OUT      (2),
        .WIDTH         (16),
        .DEPTH         (64),
        .FLUSH_TIMEOUT (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .m_ready    (m_ready),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_keep     (m_keep),
        .m_overflow (m_overflow),
        .fill_level (fill_level),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        s_valid = 4'b0000;
        for (int i = 0; i < 4; i++) s_data[i] = 16'h0000;
    endtask

    task automatic drive_beat(input logic [3:0] v, input bit push, input bit droppable,
                              input bit ovf_first);
        bit        first;
        sb_entry_t e;
        first   = 1'b1;
        s_valid = v;
        for (int i = 0; i < 4; i++) begin
            if (v[i]) begin
                s_data[i] = seq;
                if (push) begin
                    e.data      = seq;
                    e.ovf       = ovf_first && first;
                    e.droppable = droppable;
                    sb.push_back(e);
                end
                first = 1'b0;
                seq   = seq + 16'd1;
            end else begin
                s_data[i] = 16'hDEAD;
            end
        end
    endtask

    // Two sparse words on lanes 1 and 3, m_ready held high; called at posedge+1.
    task automatic run_t1(input string pfx);
        sb_entry_t e;
        s_valid   = 4'b1010;
        s_data[0] = 16'hBEEF;
        s_data[1] = 16'h0011;
        s_data[2] = 16'hBEEF;
        s_data[3] = 16'h0033;
        e.ovf = 1'b0; e.droppable = 1'b0;
        e.data = 16'h0011; sb.push_back(e);
        e.data = 16'h0033; sb.push_back(e);
        tick();
        idle();
        @(negedge clk);
        chk({pfx, "_valid_after1"}, 32'(m_valid), 32'd0);
        tick();
        @(negedge clk);
        chk({pfx, "_valid_after2"}, 32'(m_valid), 32'd1);
        chk({pfx, "_keep"}, 32'(m_keep), 32'h3);
        chk({pfx, "_data0"}, 32'(m_data[0]), 32'h0011);
        chk({pfx, "_data1"}, 32'(m_data[1]), 32'h0033);
        chk({pfx, "_ovf"}, 32'(m_overflow), 32'd0);
        tick();
        tick();
        @(negedge clk);
        chk({pfx, "_fill_empty"}, 32'(fill_level), 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        sb_entry_t ent;
        bit        beat_ovf;
        bit        exp_ovf;
        if (rst) begin
            lazy_pending = 1'b0;
        end else if (m_valid && m_ready) begin
            beat_ovf = 1'b0;
            chk("mon_keep_shape", 32'((m_keep == 2'b01) || (m_keep == 2'b11)), 32'd1);
            for (int i = 0; i < 2; i++) begin
                if (m_keep[i]) begin
                    while ((sb.size() >= 4) && sb[0].droppable && (sb[0].data !== m_data[i])) begin
                        for (int j = 0; j < 4; j++) ent = sb.pop_front();
                        total_skipped++;
                        lazy_pending = 1'b1;
                    end
                    checks++;
                    assert (sb.size() != 0) else begin
                        failures++;
                        $error("FAIL mon_unexpected_word observed=%0h expected=none", m_data[i]);
                    end
                    if (sb.size() != 0) begin
                        ent     = sb.pop_front();
                        exp_ovf = ent.ovf | lazy_pending;
                        lazy_pending = 1'b0;
                        chk("mon_data", 32'(m_data[i]), 32'(ent.data));
                        beat_ovf = beat_ovf | exp_ovf;
                    end
                end
            end
            chk("mon_overflow", 32'(m_overflow), 32'(beat_ovf));
        end
    end

    initial begin
        logic [15:0] word;
        logic [31:0] base_drop;
        int          base_skip;
        checks        = 0;
        failures      = 0;
        total_skipped = 0;
        lazy_pending  = 1'b0;
        seq           = 16'h1000;
        rst           = 1'b1;
        m_ready       = 1'b0;
        idle();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(m_valid), 32'd0);
        chk("rst_keep", 32'(m_keep), 32'd0);
        chk("rst_ovf", 32'(m_overflow), 32'd0);
        chk("rst_fill", 32'(fill_level), 32'd0);
        chk("rst_drops", drop_count, 32'd0);
        tick();
        rst     = 1'b0;
        m_ready = 1'b1;

        // Test 1: sparse beat meets the threshold, 2-cycle latency
        run_t1("t1");

        // Test 2: single word waits for the idle timeout
        word = seq;
        drive_beat(4'b0100, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        @(negedge clk);
        chk("t2_valid_s1", 32'(m_valid), 32'd0);
        for (int k = 0; k < 8; k++) begin
            tick();
            @(negedge clk);
            chk("t2_wait_valid", 32'(m_valid), 32'd0);
        end
        tick();
        @(negedge clk);
        chk("t2_timeout_valid", 32'(m_valid), 32'd1);
        chk("t2_keep", 32'(m_keep), 32'h1);
        chk("t2_data0", 32'(m_data[0]), 32'(word));
        chk("t2_fill_before", 32'(fill_level), 32'd1);
        tick();
        @(negedge clk);
        chk("t2_fill_after", 32'(fill_level), 32'd0);

        // Test 3: fill to capacity with m_ready low, 17th beat dropped
        tick();
        m_ready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            drive_beat(4'b1111, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive_beat(4'b1111, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        repeat (4) tick();
        @(negedge clk);
        chk("t3_drops", drop_count, 32'd1);
        chk("t3_fill_full", 32'(fill_level), 32'd64);
        chk("t3_valid_held", 32'(m_valid), 32'd1);
        chk("t3_ovf_head", 32'(m_overflow), 32'd0);
        tick();
        m_ready = 1'b1;
        repeat (4) tick();
        drive_beat(4'b1111, 1'b1, 1'b0, 1'b1);
        tick();
        idle();
        repeat (45) tick();
        @(negedge clk);
        chk("t3_fill_drained", 32'(fill_level), 32'd0);
        chk("t3_sb_empty", 32'(sb.size()), 32'd0);

        // Test 4: continuous full beats, output at half rate, across pointer wrap
        tick();
        base_drop = drop_count;
        base_skip = total_skipped;
        for (int c = 0; c < 200; c++) begin
            drive_beat(4'b1111, 1'b1, 1'b1, 1'b0);
            tick();
        end
        idle();
        repeat (60) tick();
        @(negedge clk);
        chk("t4_drop_count", drop_count - base_drop,
            32'(total_skipped - base_skip) + 32'(sb.size() / 4));
        chk("t4_some_dropped", 32'(drop_count != base_drop), 32'd1);
        chk("t4_fill_drained", 32'(fill_level), 32'd0);

        // Test 5: same-cycle pop does not free room for admission
        tick();
        m_ready = 1'b0;
        for (int b = 0; b < 15; b++) begin
            drive_beat(4'b1111, 1'b1, 1'b0, 1'b0);
            tick();
        end
        drive_beat(4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        repeat (4) tick();
        @(negedge clk);
        chk("t5_fill_62", 32'(fill_level), 32'd62);
        base_drop = drop_count;
        tick();
        drive_beat(4'b1111, 1'b0, 1'b0, 1'b0);
        tick();
        drive_beat(4'b1111, 1'b1, 1'b0, 1'b1);
        m_ready = 1'b1;
        tick();
        idle();
        @(negedge clk);
        chk("t5_fill_60", 32'(fill_level), 32'd60);
        chk("t5_drop_inc", drop_count - base_drop, 32'd1);
        tick();
        @(negedge clk);
        chk("t5_fill_accept", 32'(fill_level), 32'd62);
        repeat (50) tick();
        @(negedge clk);
        chk("t5_fill_drained", 32'(fill_level), 32'd0);
        chk("t5_sb_empty", 32'(sb.size()), 32'd0);

        // Test 6: asynchronous reset mid-stream
        tick();
        m_ready = 1'b0;
        drive_beat(4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        drive_beat(4'b1111, 1'b1, 1'b0, 1'b0);
        tick();
        drive_beat(4'b0011, 1'b1, 1'b0, 1'b0);
        tick();
        idle();
        repeat (4) tick();
        @(negedge clk);
        chk("t6_fill_10", 32'(fill_level), 32'd10);
        chk("t6_valid_pre", 32'(m_valid), 32'd1);
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(m_valid), 32'd0);
        chk("t6_async_fill", 32'(fill_level), 32'd0);
        chk("t6_async_drops", drop_count, 32'd0);
        chk("t6_async_keep", 32'(m_keep), 32'd0);
        sb.delete();
        repeat (2) tick();
        rst     = 1'b0;
        m_ready = 1'b1;
        run_t1("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
